// File: rtl/rx_intf_pkt_packer_pkg.sv
// Shared definitions for the rx_intf packet packer: header field layout and FSM encoding.
package rx_intf_pkt_packer_pkg;

    localparam int HDR_WORDS = 2;

    localparam int LEN_LSB  = 0;
    localparam int RATE_LSB = 16;
    localparam int RSSI_LSB = 20;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_HDR0    = 3'd1;
    localparam state_t ST_HDR1    = 3'd2;
    localparam state_t ST_PAYLOAD = 3'd3;
    localparam state_t ST_TRIG    = 3'd4;

    function automatic logic [63:0] build_hdr(input logic [15:0] len,
                                              input logic [3:0]  rate,
                                              input logic [10:0] rssi);
        logic [63:0] h;
        h = '0;
        h[LEN_LSB  +: 16] = len;
        h[RATE_LSB +: 4]  = rate;
        h[RSSI_LSB +: 11] = rssi;
        return h;
    endfunction

endpackage

// File: rtl/rx_intf_pkt_packer_if.sv
// Packer-to-DMA-master FIFO port: word write strobe, transfer trigger and FIFO status.
interface rx_intf_pkt_packer_if #(
    parameter int DW = 64,
    parameter int SW = 14
);
    logic [DW-1:0] data_to_acc;
    logic          data_ready_to_acc;
    logic          start_1trans;
    logic [SW-1:0] num_dma_symbol;
    logic [SW-1:0] fifo_data_count;
    logic          fifo_fulln;

    modport master (
        output data_to_acc, data_ready_to_acc, start_1trans, num_dma_symbol,
        input  fifo_data_count, fifo_fulln
    );

    modport slave (
        input  data_to_acc, data_ready_to_acc, start_1trans, num_dma_symbol,
        output fifo_data_count, fifo_fulln
    );
endinterface

// File: rtl/rx_intf_pkt_packer.sv
// Prepends a two-word header to each received packet and packs payload bytes
// little-endian into 64-bit words for the DMA master FIFO.
//   state   | meaning
//   IDLE    | waiting for an admissible pkt_start
//   HDR0    | writing timestamp word
//   HDR1    | writing len/rate/rssi header word
//   PAYLOAD | writing packed payload words as they complete
//   TRIG    | start_1trans pulse, symbol count presented
module rx_intf_pkt_packer
    import rx_intf_pkt_packer_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH   = 64,
    parameter int MAX_NUM_DMA_SYMBOL     = 8192,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_start,
    input  logic [15:0] pkt_len,
    input  logic [63:0] timestamp,
    input  logic [10:0] rssi_half_db,
    input  logic [3:0]  rate,
    input  logic [7:0]  byte_in,
    input  logic        byte_in_valid,
    rx_intf_pkt_packer_if.master dma,
    output logic        pkt_drop,
    output logic        busy
);
    localparam int DW = C_M_AXIS_TDATA_WIDTH;
    localparam int SW = MAX_BIT_NUM_DMA_SYMBOL;

    state_t        state, state_nxt;
    logic [15:0]   len_q;
    logic [63:0]   ts_q;
    logic [10:0]   rssi_q;
    logic [3:0]    rate_q;
    logic [16:0]   need_q;
    logic [15:0]   byte_cnt;
    logic [DW-1:0] pack_q;
    logic          wq_valid, wq_last;
    logic [DW-1:0] wq_data;
    logic [SW-1:0] nds_q;
    logic          drop_q;

    logic [16:0]   len_ext, need_w;
    logic          fits, accept;
    logic          byte_ok, last_byte, word_done, wq_write;
    logic [2:0]    lane;
    logic [DW-1:0] word_cur;
    logic [DW-1:0] wr_data;
    logic          wr_en, trig;

    // Admission: need computed in 17 bits so a 64 KiB packet cannot wrap.
    always_comb begin
        len_ext = {1'b0, pkt_len};
        need_w  = 17'(HDR_WORDS) + ((len_ext + 17'd7) >> 3);
        fits    = (need_w + 17'(dma.fifo_data_count)) <= 17'(MAX_NUM_DMA_SYMBOL);
        accept  = pkt_start && (state == ST_IDLE) && fits;
    end

    always_comb begin
        byte_ok   = byte_in_valid && (byte_cnt < len_q) &&
                    ((state == ST_HDR0) || (state == ST_HDR1) || (state == ST_PAYLOAD));
        lane      = byte_cnt[2:0];
        last_byte = (byte_cnt == (len_q - 16'd1));
        word_done = byte_ok && ((lane == 3'd7) || last_byte);
        word_cur  = pack_q | (DW'(byte_in) << {lane, 3'b000});
        wq_write  = (state == ST_PAYLOAD) && wq_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept) state_nxt = ST_HDR0;
            ST_HDR0:    state_nxt = ST_HDR1;
            ST_HDR1:    state_nxt = (len_q == 16'd0) ? ST_TRIG : ST_PAYLOAD;
            ST_PAYLOAD: if (wq_write && wq_last) state_nxt = ST_TRIG;
            ST_TRIG:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        trig    = 1'b0;
        case (state)
            ST_HDR0: begin
                wr_en   = 1'b1;
                wr_data = DW'(ts_q);
            end
            ST_HDR1: begin
                wr_en   = 1'b1;
                wr_data = DW'(build_hdr(len_q, rate_q, rssi_q));
            end
            ST_PAYLOAD: begin
                wr_en   = wq_valid;
                wr_data = wq_valid ? wq_data : '0;
            end
            ST_TRIG:  trig = 1'b1;
            default: ;
        endcase
    end

    // wq holds one completed word; a word finishing during the header
    // writes simply waits here until the first PAYLOAD cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            ts_q     <= '0;
            rssi_q   <= '0;
            rate_q   <= '0;
            need_q   <= '0;
            byte_cnt <= '0;
            pack_q   <= '0;
            wq_valid <= 1'b0;
            wq_last  <= 1'b0;
            wq_data  <= '0;
            nds_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= pkt_start && !accept;
            if (accept) begin
                len_q    <= pkt_len;
                ts_q     <= timestamp;
                rssi_q   <= rssi_half_db;
                rate_q   <= rate;
                need_q   <= need_w;
                byte_cnt <= '0;
                pack_q   <= '0;
                wq_valid <= 1'b0;
                wq_last  <= 1'b0;
            end else begin
                if (byte_ok) begin
                    byte_cnt <= byte_cnt + 16'd1;
                    pack_q   <= word_done ? '0 : word_cur;
                end
                if (word_done) begin
                    wq_valid <= 1'b1;
                    wq_data  <= word_cur;
                    wq_last  <= last_byte;
                end else if (wq_write) begin
                    wq_valid <= 1'b0;
                    wq_last  <= 1'b0;
                end
            end
            if (state_nxt == ST_TRIG) nds_q <= SW'(need_q - 17'd1);
        end
    end

    assign dma.data_to_acc       = wr_data;
    assign dma.data_ready_to_acc = wr_en;
    assign dma.start_1trans      = trig;
    assign dma.num_dma_symbol    = nds_q;
    assign pkt_drop              = drop_q;
    assign busy                  = (state != ST_IDLE);

endmodule

// File: tb/tb_rx_intf_pkt_packer.sv
// Bench for rx_intf_pkt_packer: vector table of packets plus hand-built corner sequences,
// with a scoreboard of expected FIFO words and symbol counts.
module tb_rx_intf_pkt_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_start;
    logic [15:0] pkt_len;
    logic [63:0] timestamp;
    logic [10:0] rssi_half_db;
    logic [3:0]  rate;
    logic [7:0]  byte_in;
    logic        byte_in_valid;
    logic        pkt_drop;
    logic        busy;

    rx_intf_pkt_packer_if #(.DW(64), .SW(14)) dma_if();

    always #5 clk = ~clk;

    assign dma_if.fifo_fulln = (dma_if.fifo_data_count < 14'd8192);

    rx_intf_pkt_packer #(
        .C_M_AXIS_TDATA_WIDTH(64),
        .MAX_NUM_DMA_SYMBOL(8192),
        .MAX_BIT_NUM_DMA_SYMBOL(14)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pkt_start(pkt_start),
        .pkt_len(pkt_len),
        .timestamp(timestamp),
        .rssi_half_db(rssi_half_db),
        .rate(rate),
        .byte_in(byte_in),
        .byte_in_valid(byte_in_valid),
        .dma(dma_if.master),
        .pkt_drop(pkt_drop),
        .busy(busy)
    );

    typedef struct {
        logic [15:0] len;
        logic [63:0] ts;
        logic [10:0] rssi;
        logic [3:0]  rate;
        logic [13:0] fcnt;
        logic [7:0]  base;
        int          extra;
        int          intrude;
        bit          exp_drop;
        logic [13:0] exp_nds;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int n_wr = 0;
    int n_start = 0;
    int n_drop = 0;
    logic [63:0] wq[$];
    logic [13:0] nq[$];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [15:0] len, input logic [63:0] ts, input logic [13:0] fcnt,
                                input logic [7:0] base, input int extra, input int intrude,
                                input bit exp_drop, input logic [13:0] exp_nds);
        vec_t v;
        v.len = len; v.ts = ts; v.rssi = 11'h5A3; v.rate = 4'hB; v.fcnt = fcnt;
        v.base = base; v.extra = extra; v.intrude = intrude;
        v.exp_drop = exp_drop; v.exp_nds = exp_nds;
        return v;
    endfunction

    task automatic push_expect(input vec_t v);
        int nwords;
        logic [63:0] w;
        wq.push_back(v.ts);
        wq.push_back({33'b0, v.rssi, v.rate, v.len});
        nwords = (int'(v.len) + 7) / 8;
        for (int i = 0; i < nwords; i++) begin
            w = '0;
            for (int b = 0; b < 8; b++) begin
                if (i * 8 + b < int'(v.len)) w[8*b +: 8] = 8'(int'(v.base) + i * 8 + b);
            end
            wq.push_back(w);
        end
        nq.push_back(v.exp_nds);
    endtask

    task automatic drive_start(input vec_t v);
        pkt_start    = 1'b1;
        pkt_len      = v.len;
        timestamp    = v.ts;
        rssi_half_db = v.rssi;
        rate         = v.rate;
        dma_if.fifo_data_count = v.fcnt;
    endtask

    task automatic wait_starts(input string name, input int target);
        int guard;
        guard = 0;
        while (n_start < target && guard < 300) begin
            tick();
            guard++;
        end
        check64(name, 64'(n_start), 64'(target));
    endtask

    task automatic run_pkt(input int idx, input vec_t v);
        int s0, d0, w0;
        s0 = n_start; d0 = n_drop; w0 = n_wr;
        if (!v.exp_drop) push_expect(v);
        drive_start(v);
        tick();
        pkt_start = 1'b0;
        for (int k = 0; k < int'(v.len) + v.extra; k++) begin
            byte_in       = 8'(int'(v.base) + k);
            byte_in_valid = 1'b1;
            if (k == v.intrude) begin
                pkt_start = 1'b1;
                pkt_len   = 16'd4;
                dma_if.fifo_data_count = 14'd0;
            end
            tick();
            pkt_start = 1'b0;
        end
        byte_in_valid = 1'b0;
        if (v.exp_drop) begin
            repeat (4) tick();
            check64($sformatf("v%0d_drop_pulse", idx), 64'(n_drop), 64'(d0 + 1));
            check64($sformatf("v%0d_drop_no_write", idx), 64'(n_wr), 64'(w0));
            check64($sformatf("v%0d_drop_no_start", idx), 64'(n_start), 64'(s0));
        end else begin
            wait_starts($sformatf("v%0d_start_seen", idx), s0 + 1);
            tick();
            check64($sformatf("v%0d_drop_count", idx), 64'(n_drop), 64'(d0 + ((v.intrude >= 0) ? 1 : 0)));
            check64($sformatf("v%0d_words_left", idx), 64'(wq.size()), 64'd0);
            check64($sformatf("v%0d_idle_after", idx), 64'(busy), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (dma_if.data_ready_to_acc) begin
            n_wr++;
            check64("fifo_fulln_at_write", 64'(dma_if.fifo_fulln), 64'd1);
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %h expected no write", dma_if.data_to_acc);
            end else begin
                check64("write_data", dma_if.data_to_acc, wq.pop_front());
            end
        end
        if (dma_if.start_1trans) begin
            n_start++;
            check64("writes_done_before_trig", 64'(wq.size()), 64'd0);
            if (nq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: got start_1trans expected none");
            end else begin
                check64("num_dma_symbol", 64'(dma_if.num_dma_symbol), 64'(nq.pop_front()));
            end
        end
        if (pkt_drop) n_drop++;
    end

    vec_t vecs[9];
    vec_t v;
    int s0, d0;

    initial begin
        vecs[0] = mk(16'd16, 64'h1122334455667788, 14'd0,    8'h00, 0, -1, 1'b0, 14'd3);
        vecs[1] = mk(16'd13, 64'h0123456789ABCDEF, 14'd0,    8'h00, 3, -1, 1'b0, 14'd3);
        vecs[2] = mk(16'd0,  64'hCAFEF00D00000001, 14'd100,  8'h00, 0, -1, 1'b0, 14'd1);
        vecs[3] = mk(16'd1,  64'h00000000DEADBEEF, 14'd0,    8'hAA, 0, -1, 1'b0, 14'd2);
        vecs[4] = mk(16'd8,  64'h5555AAAA5555AAAA, 14'd8190, 8'h10, 0, -1, 1'b1, 14'd0);
        vecs[5] = mk(16'd8,  64'h0F0F0F0F0F0F0F0F, 14'd0,    8'h40, 0, -1, 1'b0, 14'd2);
        vecs[6] = mk(16'd16, 64'h7777666655554444, 14'd0,    8'h80, 0, 5,  1'b0, 14'd3);
        vecs[7] = mk(16'd8,  64'h1000000000000001, 14'd8189, 8'hC0, 0, -1, 1'b0, 14'd2);
        vecs[8] = mk(16'd9,  64'h2000000000000002, 14'd0,    8'hF0, 0, -1, 1'b0, 14'd3);

        rst = 1'b1; pkt_start = 1'b0; pkt_len = '0; timestamp = '0; rssi_half_db = '0;
        rate = '0; byte_in = '0; byte_in_valid = 1'b0; dma_if.fifo_data_count = '0;
        repeat (3) tick();
        check64("rst_busy", 64'(busy), 64'd0);
        check64("rst_wr", 64'(dma_if.data_ready_to_acc), 64'd0);
        check64("rst_data", dma_if.data_to_acc, 64'd0);
        check64("rst_start", 64'(dma_if.start_1trans), 64'd0);
        check64("rst_nds", 64'(dma_if.num_dma_symbol), 64'd0);
        check64("rst_drop", 64'(pkt_drop), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run_pkt(i, vecs[i]);

        // pkt_start landing in the TRIG cycle is dropped; the next cycle is accepted
        v = mk(16'd0, 64'hABCD000000000001, 14'd0, 8'h00, 0, -1, 1'b0, 14'd1);
        s0 = n_start; d0 = n_drop;
        push_expect(v);
        drive_start(v);
        tick();
        pkt_start = 1'b0;
        tick();
        tick();
        check64("trig_state_start", 64'(dma_if.start_1trans), 64'd1);
        pkt_start = 1'b1;
        tick();
        v.ts = 64'hABCD000000000002;
        push_expect(v);
        drive_start(v);
        tick();
        pkt_start = 1'b0;
        wait_starts("b2b_starts", s0 + 2);
        tick();
        check64("b2b_drop_count", 64'(n_drop), 64'(d0 + 1));

        // reset in the middle of PAYLOAD abandons the packet
        v = mk(16'd16, 64'h3333333333333333, 14'd0, 8'h20, 0, -1, 1'b0, 14'd3);
        s0 = n_start;
        wq.push_back(v.ts);
        wq.push_back({33'b0, v.rssi, v.rate, v.len});
        drive_start(v);
        tick();
        pkt_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            byte_in = 8'(int'(v.base) + k);
            byte_in_valid = 1'b1;
            tick();
        end
        check64("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        byte_in_valid = 1'b0;
        tick();
        check64("mrst_busy", 64'(busy), 64'd0);
        check64("mrst_wr", 64'(dma_if.data_ready_to_acc), 64'd0);
        check64("mrst_nds", 64'(dma_if.num_dma_symbol), 64'd0);
        check64("mrst_start", 64'(dma_if.start_1trans), 64'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check64("mrst_no_start", 64'(n_start), 64'(s0));
        check64("mrst_words_left", 64'(wq.size()), 64'd0);
        run_pkt(20, mk(16'd5, 64'h4444444444444444, 14'd0, 8'h60, 0, -1, 1'b0, 14'd2));

        check64("final_nq_empty", 64'(nq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_intf_pkt_packer.md
Name: rx_intf_pkt_packer

Overview:
- Upstream feeder of the rx_intf AXI-Stream DMA master.
- Takes the per-packet byte stream from the receiver, prepends a 2-word header, and packs payload bytes little-endian into 64-bit words.
- Writes those words into the DMA master's FIFO (data/ready/fulln interface). On packet completion it pulses start_1trans and presents the word count minus one as the DMA symbol count.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 64: word width; only 64 is supported.
- MAX_NUM_DMA_SYMBOL, 8192: downstream FIFO depth in words.
- MAX_BIT_NUM_DMA_SYMBOL, 14: width of the symbol count and FIFO data count.
- HDR_WORDS, 2: header words per packet; fixed.

Ports:
- clk  in  1  single clock, shared with the DMA master.
- rst  in  1  synchronous, active-high reset.
- pkt_start  in  1  one-cycle pulse; pkt_len, timestamp, rssi_half_db and rate are valid in this cycle.
- pkt_len  in  16  payload length in bytes.
- timestamp  in  64  packet timestamp.
- rssi_half_db  in  11  RSSI, 0.5 dB units.
- rate  in  4  PHY rate code.
- byte_in  in  8  payload byte.
- byte_in_valid  in  1  byte strobe, at most one byte per cycle; not stallable.
- fifo_data_count  in  MAX_BIT_NUM_DMA_SYMBOL  current occupancy of the downstream FIFO.
- fifo_fulln  in  1  downstream FIFO not full.
- data_to_acc  out  64  word to the FIFO.
- data_ready_to_acc  out  1  FIFO write strobe.
- start_1trans  out  1  one-cycle pulse, packet fully written.
- num_dma_symbol  out  MAX_BIT_NUM_DMA_SYMBOL  total words minus 1.
- pkt_drop  out  1  one-cycle pulse, packet rejected.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter and pack register cleared. Reset mid-packet abandons the packet with no start_1trans; the downstream FIFO shares the reset.
- Word count: need = 2 + ceil(pkt_len/8), computed in 17 bits with no wrap.
- Admission, evaluated only in the pkt_start cycle:
  - Accept if need <= MAX_NUM_DMA_SYMBOL - fifo_data_count.
  - Otherwise pulse pkt_drop the next cycle, stay IDLE, and ignore this packet's bytes.
  - Since fifo occupancy only falls while a packet is in progress, fifo_fulln is never low at a write; the bench asserts this.
- Accept action: latch header fields and need, clear the byte counter, go to HDR0.
- State machine:
  - IDLE: wait for pkt_start.
  - HDR0: write timestamp; go to HDR1.
  - HDR1: write {33'b0, rssi_half_db[30:20], rate[19:16], pkt_len[15:0]}; go to PAYLOAD, or TRIG if pkt_len == 0.
  - PAYLOAD: write completed words; go to TRIG after the write of the final word.
  - TRIG: drive start_1trans=1 and num_dma_symbol=need-1 for one cycle; go to IDLE.
- Byte acceptance:
  - Bytes count only in HDR0, HDR1 and PAYLOAD, and only while count < pkt_len.
  - Byte k of the payload goes to bits [8*(k%8)+7 : 8*(k%8)].
  - Bytes in IDLE or TRIG, and bytes beyond pkt_len, are ignored.
- Word write timing:
  - A word completes when k%8 == 7, or when k == pkt_len-1; a final partial word is zero-padded in its upper bytes.
  - The completed word is written the cycle after its completing byte, with data_ready_to_acc high for exactly one cycle per word.
- Collision with header writes:
  - If a word completes during HDR0 or HDR1 (only possible when pkt_len <= 2), it is held in a one-entry pending register.
  - It is written on the first PAYLOAD cycle.
  - At most one word is ever pending.
- Write ordering: writes are strictly timestamp, header, then payload words in order; never two writes in one cycle.
- num_dma_symbol: holds its value until the next TRIG.
- pkt_start while busy: ignored, with pkt_drop pulsed the next cycle; the current packet is unaffected.
- Back-to-back packets: pkt_start in the TRIG cycle is ignored with pkt_drop; pkt_start is accepted from IDLE onward.

Decomposition:
- Shared package: header bit-field offsets (LEN_LSB=0, RATE_LSB=16, RSSI_LSB=20), HDR_WORDS, and the state encoding (IDLE, HDR0, HDR1, PAYLOAD, TRIG as a 3-bit localparam).
- Single module; the pack register, pending register and admission arithmetic are small enough not to warrant a sub-module.

Test Plan:
- len=16, bytes 0x00..0x0F back-to-back starting 1 cycle after pkt_start, timestamp 0x1122334455667788 -> 4 writes: 0x1122334455667788, header with len 0x0010, 0x0706050403020100, 0x0F0E0D0C0B0A0908; start_1trans one cycle after the last write; num_dma_symbol=3.
- len=13, bytes 0x00..0x0C -> last word 0x0000000C0B0A0908; num_dma_symbol=3.
- len=0 -> exactly 2 writes, then TRIG; num_dma_symbol=1.
- len=1, byte 0xAA in the cycle after pkt_start -> word held pending; writes in order ts, header, 0x00000000000000AA; num_dma_symbol=2.
- fifo_data_count=8190, len=8 (need 3 > free 2) -> pkt_drop pulse, zero writes, no start_1trans; following packet with fifo_data_count=0 is accepted normally.
- pkt_start during PAYLOAD -> pkt_drop, first packet completes intact. Then rst asserted mid-PAYLOAD of a new packet -> all outputs 0, busy=0, no start_1trans; next packet after reset is correct.
